// File: rtl/gate_bist_if.sv
// Bus bundle for gate_bist: run control, golden signature and status/observation outputs.
interface gate_bist_if #(
  parameter int N_IN  = 4,
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] expected_sig;
  logic [N_IN-1:0]  pat;
  logic             pat_valid;
  logic [9:0]       gate_out;
  logic             gate_valid;
  logic [SIG_W-1:0] signature;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    output start, abort, expected_sig,
    input  pat, pat_valid, gate_out, gate_valid, signature, busy, done, pass
  );

  modport slave (
    input  start, abort, expected_sig,
    output pat, pat_valid, gate_out, gate_valid, signature, busy, done, pass
  );
endinterface

// File: rtl/gate_bist.sv
// gate_bist: pattern generator (counter or LFSR) -> ten-gate bank -> registered
// outputs -> MISR, with a golden-signature compare latched when the run ends.
module gate_bist #(
  parameter int               N_IN      = 4,
  parameter int               PAT_MODE  = 0,
  parameter int               N_PAT     = 15,
  parameter logic [N_IN-1:0]  LFSR_TAPS = N_IN'(4'b1100),
  parameter logic [N_IN-1:0]  LFSR_SEED = N_IN'(4'b0001),
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] POLY      = SIG_W'(16'h1021)
) (
  input logic        clk,
  input logic        rst_n,
  gate_bist_if.slave bus
);

  localparam int              P        = (PAT_MODE == 1) ? N_PAT : (1 << N_IN);
  localparam logic [8:0]      LAST_IDX = 9'(P - 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [N_IN-1:0] SEED_EFF = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
  localparam logic [N_IN-1:0] PAT_INIT = (PAT_MODE == 1) ? SEED_EFF : '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  pat_q, pat_nxt;
  logic             pat_valid_q;
  logic [9:0]       gate_out_q, gate_d;
  logic             gate_valid_q;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             pass_q;
  logic [8:0]       idx_q;
  logic             pair_or;

  // Gate bank on the live pattern; an unpaired top bit feeds the AND-OR directly.
  always_comb begin
    pair_or = 1'b0;
    for (int i = 0; i + 1 < N_IN; i += 2) pair_or = pair_or | (pat_q[i] & pat_q[i+1]);
    if (N_IN % 2 == 1) pair_or = pair_or | pat_q[N_IN-1];
    gate_d[0] = &pat_q;
    gate_d[1] = |pat_q;
    gate_d[2] = ^pat_q;
    gate_d[3] = ~(&pat_q);
    gate_d[4] = ~(|pat_q);
    gate_d[5] = ~(^pat_q);
    gate_d[6] = ~pat_q[0];
    gate_d[7] = pat_q[0];
    gate_d[8] = pair_or;
    gate_d[9] = ~pair_or;
  end

  // Next pattern: up-counter or Fibonacci LFSR shifting toward the MSB.
  always_comb begin
    if (PAT_MODE == 1) pat_nxt = {pat_q[N_IN-2:0], ^(pat_q & LFSR_TAPS)};
    else               pat_nxt = pat_q + N_IN'(1);
  end

  // MISR step, taken only when the registered gate outputs are valid.
  always_comb begin
    sig_d = sig_q;
    if (gate_valid_q)
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(gate_out_q);
  end

  // Next-state: abort dominates; RUN ends once the last pattern has drained through the MISR.
  always_comb begin
    state_d = state_q;
    if (bus.abort) state_d = S_IDLE;
    else begin
      case (state_q)
        S_RUN:   if (!pat_valid_q) state_d = S_DONE;
        default: if (bus.start) state_d = S_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: pattern walk, gate capture, MISR and pass latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q        <= '0;
      pat_valid_q  <= 1'b0;
      gate_out_q   <= '0;
      gate_valid_q <= 1'b0;
      sig_q        <= '0;
      pass_q       <= 1'b0;
      idx_q        <= '0;
    end else if (bus.abort) begin
      // Signature is left intact for post-mortem inspection.
      pat_valid_q  <= 1'b0;
      gate_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          gate_out_q   <= gate_d;
          gate_valid_q <= pat_valid_q;
          sig_q        <= sig_d;
          if (pat_valid_q) begin
            if (idx_q < LAST_IDX) begin
              pat_q <= pat_nxt;
              idx_q <= idx_q + 9'd1;
            end else begin
              pat_valid_q <= 1'b0;
            end
          end else begin
            pass_q <= (sig_d == bus.expected_sig);
          end
        end
        default: begin
          if (bus.start) begin
            pat_q        <= PAT_INIT;
            idx_q        <= '0;
            pat_valid_q  <= 1'b1;
            gate_valid_q <= 1'b0;
            sig_q        <= '0;
            pass_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pat        = pat_q;
  assign bus.pat_valid  = pat_valid_q;
  assign bus.gate_out   = gate_out_q;
  assign bus.gate_valid = gate_valid_q;
  assign bus.signature  = sig_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.pass       = pass_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: three instances (N=4 counter, N=4 LFSR, N=5 counter)
// checked against a pattern-list / popcount reference model.
module tb_gate_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_bist_if #(.N_IN(4), .SIG_W(16)) a();
  gate_bist_if #(.N_IN(4), .SIG_W(16)) b();
  gate_bist_if #(.N_IN(5), .SIG_W(16)) c();

  gate_bist #(.N_IN(4), .PAT_MODE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  gate_bist #(.N_IN(4), .PAT_MODE(1), .N_PAT(15), .LFSR_TAPS(4'b1100),
              .LFSR_SEED(4'b0001)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  gate_bist #(.N_IN(5), .PAT_MODE(0), .LFSR_TAPS(5'b01100),
              .LFSR_SEED(5'b00001)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c));

  int          sel = 0;
  logic        start_r = 1'b0, abort_r = 1'b0;
  logic [15:0] exp_a = '0, exp_b = '0, exp_c = '0;

  assign a.start = start_r && (sel == 0);
  assign b.start = start_r && (sel == 1);
  assign c.start = start_r && (sel == 2);
  assign a.abort = abort_r;
  assign b.abort = 1'b0;
  assign c.abort = 1'b0;
  assign a.expected_sig = exp_a;
  assign b.expected_sig = exp_b;
  assign c.expected_sig = exp_c;

  // Monitor mux over the selected instance.
  logic [7:0] m_pat;
  logic [9:0] m_gout;
  logic       m_busy, m_pv, m_gvld;
  always_comb begin
    m_pat = '0; m_gout = '0; m_busy = 1'b0; m_pv = 1'b0; m_gvld = 1'b0;
    case (sel)
      0: begin m_pat = 8'(a.pat); m_gout = a.gate_out; m_busy = a.busy; m_pv = a.pat_valid; m_gvld = a.gate_valid; end
      1: begin m_pat = 8'(b.pat); m_gout = b.gate_out; m_busy = b.busy; m_pv = b.pat_valid; m_gvld = b.gate_valid; end
      default: begin m_pat = 8'(c.pat); m_gout = c.gate_out; m_busy = c.busy; m_pv = c.pat_valid; m_gvld = c.gate_valid; end
    endcase
  end

  int          errors = 0, checks = 0;
  logic [9:0]  gobs[32];
  logic [9:0]  gobs_a[32];
  logic [9:0]  gobs_c[32];
  logic [31:0] seen;
  int          repeats, npat, walk_err, cyc;

  typedef struct {
    logic [4:0] p;
    logic [9:0] g;
    int         inst;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference gate bank from popcount and pair scan.
  function automatic logic [9:0] ref_bank(input int n, input int p);
    logic [9:0] r;
    int ones = 0;
    logic any = 1'b0;
    for (int i = 0; i < n; i++) ones += (p >> i) & 1;
    r[0] = (ones == n);
    r[1] = (ones > 0);
    r[2] = ones[0];
    r[3] = !r[0];
    r[4] = !r[1];
    r[5] = !r[2];
    r[7] = p[0];
    r[6] = !p[0];
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) any = any | (p[i] & p[i+1]);
      else           any = any | p[i];
    end
    r[8] = any;
    r[9] = !any;
    return r;
  endfunction

  // Reference signature: fold the ordered pattern list through the MISR rule.
  function automatic logic [15:0] ref_sig(input int n, input int mode, input int np);
    logic [15:0] s = '0;
    logic [9:0]  g;
    int p = (mode == 1) ? 1 : 0;
    int cnt = (mode == 1) ? np : (1 << n);
    for (int k = 0; k < cnt; k++) begin
      g = ref_bank(n, p);
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {6'b0, g};
      if (mode == 1) p = ((p << 1) & 15) | (((p >> 3) ^ (p >> 2)) & 1);
      else           p = p + 1;
    end
    return s;
  endfunction

  // Start a run on instance s and watch it until busy drops (or abort at cycle abort_at).
  task automatic run(input int s, input int abort_at, output int ncyc);
    int n = 0;
    logic [7:0] prv = '0;
    sel = s; seen = '0; repeats = 0; npat = 0; walk_err = 0;
    for (int i = 0; i < 32; i++) gobs[i] = '0;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    while (m_busy && n < 100) begin
      if (m_gvld) gobs[prv[4:0]] = m_gout;
      if (m_pv) begin
        if (seen[m_pat[4:0]]) repeats++;
        seen[m_pat[4:0]] = 1'b1;
        npat++;
        if (m_pat != 8'(n)) walk_err++;
      end
      prv = m_pat;
      if (n == abort_at) begin
        abort_r = 1'b1; start_r = 1'b1;
        @(negedge clk);
        abort_r = 1'b0; start_r = 1'b0;
        n++;
        break;
      end
      n++;
      @(negedge clk);
    end
    if (m_busy && abort_at < 0) chk("run_timeout", 32'(m_busy), 32'd0);
    ncyc = n;
  endtask

  logic [15:0] gold_a, gold_b, gold_c, rnd;
  logic        coin;
  int          rp;

  initial begin
    tv[0] = '{5'b00101, 10'b1010101010, 0};
    tv[1] = '{5'b01111, 10'b0110100011, 0};
    tv[2] = '{5'b00000, 10'b1001111000, 0};
    tv[3] = '{5'b10000, 10'b0101001110, 2};
    tv[4] = '{5'b11111, 10'b0110000111, 2};
    gold_a = ref_sig(4, 0, 16);
    gold_b = ref_sig(4, 1, 15);
    gold_c = ref_sig(5, 0, 32);

    // Reset state
    #3;
    chk("rst_a_ctl", 32'({a.pat, a.gate_out, a.pass, a.done, a.busy, a.pat_valid, a.gate_valid}), 32'd0);
    chk("rst_a_sig", 32'(a.signature), 32'd0);
    chk("rst_b_ctl", 32'({b.pat, b.gate_out, b.pass, b.done, b.busy, b.pat_valid, b.gate_valid}), 32'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 golden run
    exp_a = gold_a;
    run(0, -1, cyc);
    chk("a_busy_cycles", 32'(cyc), 32'd17);
    chk("a_walk", 32'(walk_err), 32'd0);
    chk("a_npat", 32'(npat), 32'd16);
    chk("a_done", 32'(a.done), 32'd1);
    chk("a_pass", 32'(a.pass), 32'd1);
    chk("a_sig", 32'(a.signature), 32'(gold_a));
    for (int i = 0; i < 32; i++) gobs_a[i] = gobs[i];

    // expected_sig changes after DONE must not disturb pass
    exp_a = ~gold_a;
    repeat (2) @(negedge clk);
    chk("a_pass_hold", 32'(a.pass), 32'd1);
    chk("a_sig_hold", 32'(a.signature), 32'(gold_a));

    // Flipped golden bit 0
    exp_a = gold_a ^ 16'h0001;
    run(0, -1, cyc);
    chk("a_flip_pass", 32'(a.pass), 32'd0);
    chk("a_flip_sig", 32'(a.signature), 32'(gold_a));

    // Randomized golden value, matching or not
    for (int it = 0; it < 3; it++) begin
      coin = 1'($urandom_range(0, 1));
      rnd = 16'($urandom);
      if (rnd == gold_a) rnd = rnd ^ 16'h8000;
      exp_a = coin ? gold_a : rnd;
      run(0, -1, cyc);
      chk("a_rand_pass", 32'(a.pass), 32'(coin));
    end

    // Randomized gate-bank spot checks against the model
    for (int it = 0; it < 8; it++) begin
      rp = int'($urandom_range(0, 15));
      chk("a_rand_bank", 32'(gobs_a[rp]), 32'(ref_bank(4, rp)));
    end

    // abort + start together in RUN cycle 5
    exp_a = gold_a;
    run(0, 5, cyc);
    chk("abort_busy", 32'(a.busy), 32'd0);
    chk("abort_done", 32'(a.done), 32'd0);
    chk("abort_gvld", 32'(a.gate_valid), 32'd0);
    chk("abort_pvld", 32'(a.pat_valid), 32'd0);
    run(0, -1, cyc);
    chk("rerun_pass", 32'(a.pass), 32'd1);
    chk("rerun_sig", 32'(a.signature), 32'(gold_a));

    // abort in DONE clears done/pass, keeps signature
    abort_r = 1'b1;
    @(negedge clk);
    abort_r = 1'b0;
    chk("abort_done_st", 32'({a.done, a.pass}), 32'd0);
    chk("abort_done_sig", 32'(a.signature), 32'(gold_a));

    // Asynchronous reset mid-run
    sel = 0;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'({a.pat, a.gate_out, a.pass, a.done, a.busy, a.pat_valid, a.gate_valid}), 32'd0);
    chk("arst_sig", 32'(a.signature), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, -1, cyc);
    chk("arst_cycles", 32'(cyc), 32'd17);
    chk("arst_pass", 32'(a.pass), 32'd1);

    // LFSR mode
    exp_b = gold_b;
    run(1, -1, cyc);
    chk("b_busy_cycles", 32'(cyc), 32'd16);
    chk("b_npat", 32'(npat), 32'd15);
    chk("b_repeats", 32'(repeats), 32'd0);
    chk("b_seen", seen, 32'h0000_FFFE);
    chk("b_done", 32'(b.done), 32'd1);
    chk("b_pass", 32'(b.pass), 32'd1);

    // Odd width, mode 0
    exp_c = gold_c;
    run(2, -1, cyc);
    chk("c_busy_cycles", 32'(cyc), 32'd33);
    chk("c_walk", 32'(walk_err), 32'd0);
    chk("c_pass", 32'(c.pass), 32'd1);
    chk("c_sig", 32'(c.signature), 32'(gold_c));
    for (int i = 0; i < 32; i++) gobs_c[i] = gobs[i];
    chk("c_g8_10000", 32'(gobs_c[16][8]), 32'd1);

    // Table of hand-derived gate vectors
    for (int i = 0; i < 5; i++) begin
      if (tv[i].inst == 0) chk("tv_a", 32'(gobs_a[tv[i].p]), 32'(tv[i].g));
      else                 chk("tv_c", 32'(gobs_c[tv[i].p]), 32'(tv[i].g));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
